// File: rtl/dift_tag_check_mc.sv
// DIFT tag check unit: per-channel 2-operand tag policy, pending/overrun/count tracking,
// and a fixed-priority trap arbiter with a held request/acknowledge handshake.
module dift_tag_check_mc #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned TAG_W  = 1,
   parameter int unsigned TYPE_W = 3,
   parameter int unsigned CNT_W  = 8,
   localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr_i,
   input  logic [NUM_CH-1:0]          ch_valid_i,
   input  logic [2*NUM_CH-1:0]        ch_mode_i,
   input  logic [NUM_CH*TAG_W-1:0]    ch_tag_a_i,
   input  logic [NUM_CH*TAG_W-1:0]    ch_tag_b_i,
   input  logic [NUM_CH*TYPE_W-1:0]   ch_type_i,
   output logic                       trap_o,
   output logic [CH_W-1:0]            trap_ch_o,
   output logic [TYPE_W-1:0]          trap_type_o,
   input  logic                       trap_ack_i,
   output logic [NUM_CH-1:0]          pend_o,
   output logic [NUM_CH-1:0]          ovr_o,
   output logic [NUM_CH*CNT_W-1:0]    cnt_o
);

   typedef enum logic [0:0] {StIdle, StTrap} state_e;

   state_e                  state_q;
   logic                    trap_q;
   logic [CH_W-1:0]         trap_ch_q;
   logic [TYPE_W-1:0]       trap_type_q;
   logic [NUM_CH-1:0]       chk, viol, req, ack_clr;
   logic [NUM_CH-1:0]       pend_d, pend_q, ovr_d, ovr_q;
   logic [NUM_CH*CNT_W-1:0] cnt_d, cnt_q;
   logic [CH_W-1:0]         gnt_idx;
   logic [TYPE_W-1:0]       gnt_type;
   logic                    gnt_vld;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_check
      logic ta, tb;
      assign ta = |ch_tag_a_i[c*TAG_W +: TAG_W];
      assign tb = |ch_tag_b_i[c*TAG_W +: TAG_W];
      always_comb begin
         chk[c] = 1'b0;
         case (ch_mode_i[2*c +: 2])
            2'b01:   chk[c] = ta | tb;
            2'b10:   chk[c] = ta & tb;
            2'b11:   chk[c] = ta;
            default: chk[c] = 1'b0;
         endcase
      end
   end

   // A clear cycle discards any violation presented alongside it.
   assign viol = ch_valid_i & chk & {NUM_CH{~clr_i}};
   assign req  = pend_q | viol;

   always_comb begin
      gnt_idx  = '0;
      gnt_type = '0;
      gnt_vld  = 1'b0;
      for (int c = int'(NUM_CH) - 1; c >= 0; c--) begin
         if (req[c]) begin
            gnt_idx  = CH_W'(c);
            gnt_type = ch_type_i[c*TYPE_W +: TYPE_W];
            gnt_vld  = 1'b1;
         end
      end
   end

   always_comb begin
      ack_clr = '0;
      if (state_q == StTrap && trap_ack_i) ack_clr[trap_ch_q] = 1'b1;
   end

   // A violation in the ack cycle re-pends the channel rather than being lost.
   always_comb begin
      pend_d = (pend_q & ~ack_clr) | viol;
      ovr_d  = ovr_q | (viol & pend_q & ~ack_clr);
      cnt_d  = cnt_q;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (viol[c] && (cnt_q[c*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
            cnt_d[c*CNT_W +: CNT_W] = cnt_q[c*CNT_W +: CNT_W] + CNT_W'(1);
         end
      end
      if (clr_i) begin
         pend_d = '0;
         ovr_d  = '0;
         cnt_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
         ovr_q  <= '0;
         cnt_q  <= '0;
      end else begin
         pend_q <= pend_d;
         ovr_q  <= ovr_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         trap_q      <= 1'b0;
         trap_ch_q   <= '0;
         trap_type_q <= '0;
      end else if (clr_i) begin
         state_q <= StIdle;
         trap_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (gnt_vld) begin
                  state_q     <= StTrap;
                  trap_q      <= 1'b1;
                  trap_ch_q   <= gnt_idx;
                  trap_type_q <= gnt_type;
               end
            end
            StTrap: begin
               if (trap_ack_i) begin
                  state_q <= StIdle;
                  trap_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= StIdle;
               trap_q  <= 1'b0;
            end
         endcase
      end
   end

   assign trap_o      = trap_q;
   assign trap_ch_o   = trap_ch_q;
   assign trap_type_o = trap_type_q;
   assign pend_o      = pend_q;
   assign ovr_o       = ovr_q;
   assign cnt_o       = cnt_q;

endmodule

// File: tb/tb_dift_tag_check_mc.sv
// Bench for dift_tag_check_mc: scenario tasks plus a trap scoreboard that pops expected
// {channel, type} records on every rising edge of trap_o.
module tb_dift_tag_check_mc;

   localparam int NUM_CH = 4;
   localparam int TAG_W  = 2;
   localparam int TYPE_W = 3;
   localparam int CNT_W  = 8;

   localparam logic [1:0] OFF = 2'b00, OR = 2'b01, AND = 2'b10, SGL = 2'b11;

   logic                      clk = 1'b0;
   logic                      rst_n = 1'b0;
   logic                      clr = 1'b0;
   logic                      ack = 1'b0;
   logic [NUM_CH-1:0]         valid = '0;
   logic [2*NUM_CH-1:0]       mode = '0;
   logic [NUM_CH*TAG_W-1:0]   tag_a = '0;
   logic [NUM_CH*TAG_W-1:0]   tag_b = '0;
   logic [NUM_CH*TYPE_W-1:0]  typ = {3'd6, 3'd2, 3'd4, 3'd1};

   logic                      trap;
   logic [1:0]                trap_ch;
   logic [TYPE_W-1:0]         trap_type;
   logic [NUM_CH-1:0]         pend, ovr;
   logic [NUM_CH*CNT_W-1:0]   cnt;

   logic                      trap2;
   logic [1:0]                trap_ch2;
   logic [TYPE_W-1:0]         trap_type2;
   logic [NUM_CH-1:0]         pend2, ovr2;
   logic [NUM_CH*2-1:0]       cnt2;

   typedef struct packed {
      logic [1:0]        ch;
      logic [TYPE_W-1:0] ty;
   } trap_t;

   trap_t exp_q[$];
   trap_t exp_item;
   int    errors = 0;
   int    checks = 0;
   int    rises = 0;
   logic  trap_prev = 1'b0;

   dift_tag_check_mc #(.NUM_CH(NUM_CH), .TAG_W(TAG_W), .TYPE_W(TYPE_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .clr_i(clr), .ch_valid_i(valid), .ch_mode_i(mode),
      .ch_tag_a_i(tag_a), .ch_tag_b_i(tag_b), .ch_type_i(typ), .trap_o(trap),
      .trap_ch_o(trap_ch), .trap_type_o(trap_type), .trap_ack_i(ack), .pend_o(pend),
      .ovr_o(ovr), .cnt_o(cnt)
   );

   dift_tag_check_mc #(.NUM_CH(NUM_CH), .TAG_W(TAG_W), .TYPE_W(TYPE_W), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .clr_i(clr), .ch_valid_i(valid), .ch_mode_i(mode),
      .ch_tag_a_i(tag_a), .ch_tag_b_i(tag_b), .ch_type_i(typ), .trap_o(trap2),
      .trap_ch_o(trap_ch2), .trap_type_o(trap_type2), .trap_ack_i(ack), .pend_o(pend2),
      .ovr_o(ovr2), .cnt_o(cnt2)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (trap && !trap_prev) begin
         rises++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_trap: got ch=%0d type=%0d, required no trap",
                     trap_ch, trap_type);
         end else begin
            exp_item = exp_q.pop_front();
            if ({trap_ch, trap_type} !== exp_item) begin
               errors++;
               $display("FAIL trap_record: got ch=%0d type=%0d, required ch=%0d type=%0d",
                        trap_ch, trap_type, exp_item.ch, exp_item.ty);
            end
         end
      end
      trap_prev = trap;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int c, input logic [1:0] m, input logic [TAG_W-1:0] a,
                         input logic [TAG_W-1:0] b, input logic v);
      mode[2*c +: 2]      = m;
      tag_a[c*TAG_W +: TAG_W] = a;
      tag_b[c*TAG_W +: TAG_W] = b;
      valid[c]            = v;
   endtask

   task automatic do_clr();
      valid = '0;
      mode  = '0;
      tag_a = '0;
      tag_b = '0;
      ack   = 1'b0;
      clr   = 1'b1;
      step();
      clr   = 1'b0;
   endtask

   function automatic logic [CNT_W-1:0] cnt_of(input int c);
      return cnt[c*CNT_W +: CNT_W];
   endfunction

   task automatic test_reset();
      #2;
      checks++;
      if ({trap, trap_ch, trap_type, pend, ovr, cnt} !== '0) begin
         errors++;
         $display("FAIL reset_state: got trap=%b ch=%0d type=%0d pend=%b ovr=%b cnt=%h, required 0",
                  trap, trap_ch, trap_type, pend, ovr, cnt);
      end
      #6 rst_n = 1'b1;
      step();
   endtask

   task automatic test_single();
      do_clr();
      exp_q.push_back('{ch: 2'd1, ty: 3'd4});
      set_ch(1, OR, 2'b01, 2'b00, 1'b1);
      step();
      valid = '0;
      checks++;
      if ({trap, trap_ch, trap_type, pend} !== {1'b1, 2'd1, 3'd4, 4'b0010}) begin
         errors++;
         $display("FAIL single_latency: got trap=%b ch=%0d type=%0d pend=%b, required 1 1 4 0010",
                  trap, trap_ch, trap_type, pend);
      end
      repeat (4) step();
      checks++;
      if ({trap, trap_ch, trap_type} !== {1'b1, 2'd1, 3'd4}) begin
         errors++;
         $display("FAIL single_hold: got trap=%b ch=%0d type=%0d, required 1 1 4",
                  trap, trap_ch, trap_type);
      end
      ack = 1'b1;
      step();
      ack = 1'b0;
      checks++;
      if ({trap, pend, cnt_of(1)} !== {1'b0, 4'b0000, 8'd1}) begin
         errors++;
         $display("FAIL single_ack: got trap=%b pend=%b cnt1=%0d, required 0 0000 1",
                  trap, pend, cnt_of(1));
      end
   endtask

   task automatic test_priority();
      do_clr();
      exp_q.push_back('{ch: 2'd0, ty: 3'd1});
      exp_q.push_back('{ch: 2'd2, ty: 3'd2});
      set_ch(0, AND, 2'b10, 2'b01, 1'b1);
      set_ch(2, SGL, 2'b01, 2'b00, 1'b1);
      step();
      valid = '0;
      checks++;
      if ({trap, trap_ch, pend} !== {1'b1, 2'd0, 4'b0101}) begin
         errors++;
         $display("FAIL prio_first: got trap=%b ch=%0d pend=%b, required 1 0 0101",
                  trap, trap_ch, pend);
      end
      ack = 1'b1;
      step();
      ack = 1'b0;
      checks++;
      if ({trap, pend} !== {1'b0, 4'b0100}) begin
         errors++;
         $display("FAIL prio_gap: got trap=%b pend=%b, required 0 0100", trap, pend);
      end
      step();
      checks++;
      if ({trap, trap_ch, trap_type, pend} !== {1'b1, 2'd2, 3'd2, 4'b0100}) begin
         errors++;
         $display("FAIL prio_second: got trap=%b ch=%0d type=%0d pend=%b, required 1 2 2 0100",
                  trap, trap_ch, trap_type, pend);
      end
      ack = 1'b1;
      step();
      ack = 1'b0;
      checks++;
      if ({trap, pend} !== {1'b0, 4'b0000}) begin
         errors++;
         $display("FAIL prio_done: got trap=%b pend=%b, required 0 0000", trap, pend);
      end
   endtask

   task automatic test_overrun();
      int r0;
      do_clr();
      r0 = rises;
      exp_q.push_back('{ch: 2'd3, ty: 3'd6});
      set_ch(3, OR, 2'b00, 2'b11, 1'b1);
      step();
      checks++;
      if ({trap, trap_ch, pend[3], ovr[3]} !== {1'b1, 2'd3, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL ovr_first: got trap=%b ch=%0d pend3=%b ovr3=%b, required 1 3 1 0",
                  trap, trap_ch, pend[3], ovr[3]);
      end
      repeat (2) step();
      valid = '0;
      repeat (2) step();
      checks++;
      if ({ovr[3], cnt_of(3), trap, rises} !== {1'b1, 8'd3, 1'b1, r0 + 1}) begin
         errors++;
         $display("FAIL ovr_flag: got ovr3=%b cnt3=%0d trap=%b traps=%0d, required 1 3 1 %0d",
                  ovr[3], cnt_of(3), trap, rises - r0, 1);
      end
      exp_q.push_back('{ch: 2'd3, ty: 3'd6});
      ack = 1'b1;
      valid[3] = 1'b1;
      step();
      ack = 1'b0;
      valid = '0;
      checks++;
      if ({trap, pend[3], cnt_of(3)} !== {1'b0, 1'b1, 8'd4}) begin
         errors++;
         $display("FAIL ovr_ack_viol: got trap=%b pend3=%b cnt3=%0d, required 0 1 4",
                  trap, pend[3], cnt_of(3));
      end
      step();
      checks++;
      if ({trap, trap_ch} !== {1'b1, 2'd3}) begin
         errors++;
         $display("FAIL ovr_retrap: got trap=%b ch=%0d, required 1 3", trap, trap_ch);
      end
      ack = 1'b1;
      step();
      ack = 1'b0;
      checks++;
      if ({trap, pend, ovr[3]} !== {1'b0, 4'b0000, 1'b1}) begin
         errors++;
         $display("FAIL ovr_done: got trap=%b pend=%b ovr3=%b, required 0 0000 1",
                  trap, pend, ovr[3]);
      end
   endtask

   task automatic test_saturate();
      logic [1:0] exp_cnt [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
      do_clr();
      exp_q.push_back('{ch: 2'd0, ty: 3'd1});
      set_ch(0, OR, 2'b01, 2'b00, 1'b1);
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if (cnt2[1:0] !== exp_cnt[i]) begin
            errors++;
            $display("FAIL sat_cnt[%0d]: got %0d, required %0d", i, cnt2[1:0], exp_cnt[i]);
         end
      end
      valid = '0;
      checks++;
      if (cnt_of(0) !== 8'd6) begin
         errors++;
         $display("FAIL sat_wide_cnt: got %0d, required 6", cnt_of(0));
      end
      ack = 1'b1;
      step();
      ack = 1'b0;
      checks++;
      if ({trap, pend} !== {1'b0, 4'b0000}) begin
         errors++;
         $display("FAIL sat_done: got trap=%b pend=%b, required 0 0000", trap, pend);
      end
   endtask

   task automatic test_off_invalid();
      int r0;
      do_clr();
      r0 = rises;
      for (int c = 0; c < NUM_CH; c++) set_ch(c, OFF, 2'b11, 2'b11, 1'b1);
      ack = 1'b1;
      repeat (3) step();
      ack = 1'b0;
      checks++;
      if ({trap, pend, cnt} !== '0) begin
         errors++;
         $display("FAIL off_mode: got trap=%b pend=%b cnt=%h, required all 0", trap, pend, cnt);
      end
      for (int c = 0; c < NUM_CH; c++) set_ch(c, OR, 2'b11, 2'b11, 1'b0);
      repeat (3) step();
      checks++;
      if ({trap, pend, cnt, rises} !== {1'b0, 4'b0000, 32'd0, r0}) begin
         errors++;
         $display("FAIL invalid: got trap=%b pend=%b cnt=%h traps=%0d, required 0 0000 0 0",
                  trap, pend, cnt, rises - r0);
      end
   endtask

   task automatic test_clr_trap();
      do_clr();
      exp_q.push_back('{ch: 2'd2, ty: 3'd2});
      set_ch(2, SGL, 2'b10, 2'b00, 1'b1);
      step();
      valid = '0;
      step();
      checks++;
      if ({trap, trap_ch, cnt_of(2)} !== {1'b1, 2'd2, 8'd1}) begin
         errors++;
         $display("FAIL clr_setup: got trap=%b ch=%0d cnt2=%0d, required 1 2 1",
                  trap, trap_ch, cnt_of(2));
      end
      clr = 1'b1;
      set_ch(1, OR, 2'b01, 2'b00, 1'b1);
      step();
      clr = 1'b0;
      valid = '0;
      checks++;
      if ({trap, pend, ovr, cnt} !== '0) begin
         errors++;
         $display("FAIL clr_trap: got trap=%b pend=%b ovr=%b cnt=%h, required all 0",
                  trap, pend, ovr, cnt);
      end
      repeat (2) step();
      checks++;
      if ({trap, pend} !== {1'b0, 4'b0000}) begin
         errors++;
         $display("FAIL clr_discard: got trap=%b pend=%b, required 0 0000", trap, pend);
      end
   endtask

   task automatic test_reset_mid();
      do_clr();
      exp_q.push_back('{ch: 2'd1, ty: 3'd4});
      set_ch(1, OR, 2'b01, 2'b00, 1'b1);
      step();
      valid = '0;
      step();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({trap, pend, cnt} !== '0) begin
         errors++;
         $display("FAIL reset_async: got trap=%b pend=%b cnt=%h, required all 0", trap, pend, cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) step();
      checks++;
      if ({trap, pend} !== {1'b0, 4'b0000}) begin
         errors++;
         $display("FAIL reset_no_replay: got trap=%b pend=%b, required 0 0000", trap, pend);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_priority();
      test_overrun();
      test_saturate();
      test_off_invalid();
      test_clr_trap();
      test_reset_mid();
      repeat (2) step();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d expected traps unseen, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
